fetch_bundle_queue: RTL and testbench
=====================================

Name: fetch_bundle_queue

Overview:
- Sits directly downstream of the L1 instruction cache in the fetch unit.
- Buffers the 4-instruction bundles the cache emits, then issues them one instruction per cycle to decode.
- Each issued instruction carries its address, Pid, Tid and major ID.
- Applies backpressure to the cache through fetchStall_o and supports a pipeline flush.

Parameters:
- fetchingAddressWidth, 64, instruction address width.
- instructionWidth, 32, POWER fixed instruction size in bits.
- bundleSize, 128, 4 * instructionWidth.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, major instruction ID width.
- queueDepth, 4, bundle entries; power of two, minimum 2.

Ports:
- clock_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- bundleEnable_i  in  1  cache outputEnable_o; bundle fields valid this cycle.
- bundle_i  in  bundleSize  instruction 0 occupies bits [0:31], instruction k occupies [32k:32k+31].
- bundleAddress_i  in  fetchingAddressWidth  address of instruction 0.
- bundleLen_i  in  2  number of valid instructions minus 1 (0 means 1 instruction, 3 means 4).
- bundlePid_i  in  PidSize  process ID.
- bundleTid_i  in  TidSize  thread ID.
- bundleStartMajId_i  in  instructionCounterWidth  major ID of instruction 0.
- flush_i  in  1  synchronous discard of all queued and output state.
- decodeStall_i  in  1  decode cannot accept; output registers hold.
- fetchStall_o  out  1  to cache fetchStall_i.
- overflow_o  out  1  sticky error flag.
- outputEnable_o  out  1  instruction output valid.
- instruction_o  out  instructionWidth  issued instruction.
- instAddress_o  out  fetchingAddressWidth  issued instruction address.
- instPid_o  out  PidSize  issued instruction Pid.
- instTid_o  out  TidSize  issued instruction Tid.
- instMajId_o  out  instructionCounterWidth  issued instruction major ID.

Behaviour:
- Reset: asynchronous, active-high.
  - Clears the entry count, read/write pointers, sub-index and overflow_o.
  - All output registers reset to 0.
  - fetchStall_o is 0 after reset, since it follows the cleared count.
- Storage: circular buffer of queueDepth entries, each holding {bundle, address, len, Pid, Tid, startMajId}.
  - Pointers are log2(queueDepth) bits wide and wrap modulo queueDepth.
  - A sub-index (2 bits) tracks the next instruction within the head entry.
- Push: on a rising edge with bundleEnable_i=1 and the queue not full, the bundle is written at the write pointer and the write pointer increments.
- Push while full: the bundle is dropped, state is otherwise unchanged, and overflow_o is set to 1. overflow_o stays 1 until reset; flush does not clear it.
- Issue: on a rising edge with decodeStall_i=0:
  - If the queue is non-empty, the output registers load head instruction k = sub-index, with the fields below, and outputEnable_o=1.
    - instruction_o = bits [32k:32k+31] of the head bundle.
    - instAddress_o = address + 4k, truncated to fetchingAddressWidth.
    - instMajId_o = startMajId + k, wrapping.
    - instPid_o and instTid_o are copied from the head entry.
  - If k = len, the entry pops: the read pointer increments and the sub-index resets to 0. Otherwise the sub-index increments.
  - If the queue is empty, outputEnable_o=0 and the other outputs hold their last values.
- Stall: with decodeStall_i=1, all output registers and the sub-index hold; push still operates.
- Latency: a bundle pushed at edge N into an empty queue presents instruction 0 after edge N+1. A bundle of length L drains in L+1 unstalled cycles.
- Simultaneous push and pop in one edge: the count is unchanged. A push into a full queue is accepted when a pop occurs on the same edge.
- fetchStall_o: combinational, equal to (count >= queueDepth-1). This leaves one slot for a bundle already in flight in the cache pipeline.
- Flush: flush_i=1 at an edge empties the queue and zeroes the pointers and sub-index.
  - outputEnable_o goes to 0.
  - flush_i has priority over push and issue in the same cycle; the incoming bundle is discarded without setting overflow.
- Reset asserted mid-drain: outputs and queue clear immediately, without waiting for a clock edge.

Test Plan:
- Basic drain: reset, then push one bundle {AAAAAAAA,BBBBBBBB,CCCCCCCC,DDDDDDDD}, address 0x40, len 3, majId 100.
  - Required: after the next 4 edges, outputs show AAAAAAAA/0x40/100, BBBBBBBB/0x44/101, CCCCCCCC/0x48/102, DDDDDDDD/0x4C/103.
  - Required: outputEnable_o=0 on the 5th edge.
- Short bundle: push len 1 at address 0x100.
  - Required: exactly 2 instructions issue (0x100, 0x104), then the next bundle's instruction 0 follows with no bubble.
- Backpressure: push on consecutive cycles with decodeStall_i=1.
  - Required: fetchStall_o=1 once count reaches 3; the 5th push sets overflow_o=1 and is dropped.
  - Required: after releasing the stall, 16 instructions issue in order from 4 bundles.
- Decode stall mid-bundle: assert decodeStall_i for 3 cycles after instruction 1.
  - Required: instruction 1 outputs hold unchanged, then instructions 2 and 3 follow.
- Flush: with 3 bundles queued, assert flush_i together with bundleEnable_i.
  - Required: outputEnable_o=0, fetchStall_o=0 and the queue empty next cycle; overflow_o unchanged.
- Async reset: assert reset_i between clock edges during a drain.
  - Required: outputEnable_o=0 and count=0 before the next rising edge.

Source files
------------

// File: rtl/fetch_bundle_queue.sv
// Fetch bundle queue: buffers 4-instruction bundles from the L1 I-cache and
// issues them one instruction per cycle to decode, with cache backpressure,
// a sticky overflow flag and a synchronous pipeline flush.
module fetch_bundle_queue #(
  parameter int fetchingAddressWidth    = 64,
  parameter int instructionWidth        = 32,
  parameter int bundleSize              = 128,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               bundleEnable_i,
  input  logic [bundleSize-1:0]              bundle_i,
  input  logic [fetchingAddressWidth-1:0]    bundleAddress_i,
  input  logic [1:0]                         bundleLen_i,
  input  logic [PidSize-1:0]                 bundlePid_i,
  input  logic [TidSize-1:0]                 bundleTid_i,
  input  logic [instructionCounterWidth-1:0] bundleStartMajId_i,
  input  logic                               flush_i,
  input  logic                               decodeStall_i,
  output logic                               fetchStall_o,
  output logic                               overflow_o,
  output logic                               outputEnable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [fetchingAddressWidth-1:0]    instAddress_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [instructionCounterWidth-1:0] instMajId_o
);

  localparam int PTR_W = $clog2(queueDepth);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [bundleSize-1:0]              bundle;
    logic [fetchingAddressWidth-1:0]    addr;
    logic [1:0]                         len;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] maj;
  } entry_t;

  entry_t mem_q [queueDepth];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       sub_q, sub_d;
  logic             overflow_q, overflow_d;

  logic                               oe_q, oe_d;
  logic [instructionWidth-1:0]        ins_q, ins_d;
  logic [fetchingAddressWidth-1:0]    addr_q, addr_d;
  logic [PidSize-1:0]                 pid_q, pid_d;
  logic [TidSize-1:0]                 tid_q, tid_d;
  logic [instructionCounterWidth-1:0] maj_q, maj_d;

  logic   empty, full, issue, pop, push;
  entry_t head, wr_entry;
  logic [instructionWidth-1:0] ins_sel;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(queueDepth));
  assign head  = mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a full queue can still accept.
  assign issue = !flush_i && !decodeStall_i && !empty;
  assign pop   = issue && (sub_q == head.len);
  assign push  = !flush_i && bundleEnable_i && (!full || pop);

  // One slot of headroom is kept for the bundle already in the cache pipeline.
  assign fetchStall_o = (count_q >= CNT_W'(queueDepth - 1));

  assign wr_entry = '{bundle: bundle_i, addr: bundleAddress_i, len: bundleLen_i,
                      pid: bundlePid_i, tid: bundleTid_i, maj: bundleStartMajId_i};

  // Select head instruction at the current sub-index.
  always_comb begin
    ins_sel = head.bundle[instructionWidth-1:0];
    for (int k = 0; k < 4; k++) begin
      if (sub_q == 2'(k)) ins_sel = head.bundle[k*instructionWidth +: instructionWidth];
    end
  end

  // Queue bookkeeping: pointers, entry count, sub-index and sticky overflow.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    sub_d      = sub_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      sub_d    = '0;
    end else begin
      if (bundleEnable_i && full && !pop) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        sub_d    = '0;
      end else if (issue) begin
        sub_d = sub_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Output register next values; hold under decode stall or when empty.
  always_comb begin
    oe_d   = oe_q;
    ins_d  = ins_q;
    addr_d = addr_q;
    pid_d  = pid_q;
    tid_d  = tid_q;
    maj_d  = maj_q;
    if (flush_i) begin
      oe_d = 1'b0;
    end else if (!decodeStall_i) begin
      oe_d = !empty;
      if (!empty) begin
        ins_d  = ins_sel;
        addr_d = head.addr + {{(fetchingAddressWidth-4){1'b0}}, sub_q, 2'b00};
        pid_d  = head.pid;
        tid_d  = head.tid;
        maj_d  = head.maj + {{(instructionCounterWidth-2){1'b0}}, sub_q};
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      sub_q      <= '0;
      overflow_q <= 1'b0;
      oe_q       <= 1'b0;
      ins_q      <= '0;
      addr_q     <= '0;
      pid_q      <= '0;
      tid_q      <= '0;
      maj_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      sub_q      <= sub_d;
      overflow_q <= overflow_d;
      oe_q       <= oe_d;
      ins_q      <= ins_d;
      addr_q     <= addr_d;
      pid_q      <= pid_d;
      tid_q      <= tid_d;
      maj_q      <= maj_d;
    end
  end

  // Bundle storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign overflow_o     = overflow_q;
  assign outputEnable_o = oe_q;
  assign instruction_o  = ins_q;
  assign instAddress_o  = addr_q;
  assign instPid_o      = pid_q;
  assign instTid_o      = tid_q;
  assign instMajId_o    = maj_q;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Testbench for fetch_bundle_queue: scoreboard of expected issued instructions.
module tb_fetch_bundle_queue;

  logic         clock_i, reset_i, bundleEnable_i, flush_i, decodeStall_i;
  logic [127:0] bundle_i;
  logic [63:0]  bundleAddress_i, bundleStartMajId_i;
  logic [1:0]   bundleLen_i;
  logic [19:0]  bundlePid_i;
  logic [15:0]  bundleTid_i;
  logic         fetchStall_o, overflow_o, outputEnable_o;
  logic [31:0]  instruction_o;
  logic [63:0]  instAddress_o, instMajId_o;
  logic [19:0]  instPid_o;
  logic [15:0]  instTid_o;

  fetch_bundle_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .bundleEnable_i(bundleEnable_i),
    .bundle_i(bundle_i), .bundleAddress_i(bundleAddress_i), .bundleLen_i(bundleLen_i),
    .bundlePid_i(bundlePid_i), .bundleTid_i(bundleTid_i),
    .bundleStartMajId_i(bundleStartMajId_i), .flush_i(flush_i),
    .decodeStall_i(decodeStall_i), .fetchStall_o(fetchStall_o), .overflow_o(overflow_o),
    .outputEnable_o(outputEnable_o), .instruction_o(instruction_o),
    .instAddress_o(instAddress_o), .instPid_o(instPid_o), .instTid_o(instTid_o),
    .instMajId_o(instMajId_o)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] addr;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] maj;
  } item_t;

  item_t sb[$];
  bit    sbl[$];
  int    bcnt;
  logic  exp_oe, exp_fs, exp_ovf;
  item_t exp_item;
  int    total, passed;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    sb.delete(); sbl.delete();
    bcnt = 0; exp_oe = 0; exp_fs = 0; exp_ovf = 0; exp_item = '0;
  endtask

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic step(input logic en, input logic [127:0] b, input logic [63:0] a,
                      input logic [1:0] len, input logic [19:0] pid, input logic [15:0] tid,
                      input logic [63:0] maj, input logic stall, input logic flush);
    bit    pop, acc;
    item_t it;
    bundleEnable_i = en; bundle_i = b; bundleAddress_i = a; bundleLen_i = len;
    bundlePid_i = pid; bundleTid_i = tid; bundleStartMajId_i = maj;
    decodeStall_i = stall; flush_i = flush;
    pop = 0;
    if (flush) exp_oe = 0;
    else if (!stall) begin
      if (sb.size() > 0) begin
        exp_item = sb.pop_front(); pop = sbl.pop_front(); exp_oe = 1;
      end else exp_oe = 0;
    end
    acc = en && !flush && (bcnt < 4 || pop);
    if (en && !flush && !acc) exp_ovf = 1;
    @(posedge clock_i);
    if (flush) begin
      sb.delete(); sbl.delete(); bcnt = 0;
    end else begin
      bcnt = bcnt + int'(acc) - int'(pop);
      if (acc) begin
        for (int k = 0; k <= int'(len); k++) begin
          it.ins = b[k*32 +: 32]; it.addr = a + 64'(4*k); it.pid = pid; it.tid = tid;
          it.maj = maj + 64'(k);
          sb.push_back(it); sbl.push_back(k == int'(len));
        end
      end
    end
    exp_fs = (bcnt >= 3);
    #1;
    bundleEnable_i = 0; flush_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; bundleEnable_i = 0; flush_i = 0; decodeStall_i = 0; bundle_i = '0;
    bundleAddress_i = '0; bundleLen_i = '0; bundlePid_i = '0; bundleTid_i = '0;
    bundleStartMajId_i = '0;
    model_reset();
    #12;
    total++; if (outputEnable_o !== 1'b0) $display("FAIL reset_oe: got %0b want 0", outputEnable_o); else passed++;
    total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== item_t'(0))
      $display("FAIL reset_fields: got %h want 0", {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}); else passed++;
    total++; if (fetchStall_o !== 1'b0) $display("FAIL reset_fetchstall: got %0b want 0", fetchStall_o); else passed++;
    total++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow_o); else passed++;
    @(negedge clock_i);
    reset_i = 0;
  endtask

  task automatic test_basic_drain();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(1, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 64'h40, 2'd3,
                       20'h5, 16'h7, 64'd100, 0, 0);
      else step(0, '0, '0, '0, '0, '0, '0, 0, 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL drain_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL drain_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
      total++; if (fetchStall_o !== exp_fs) $display("FAIL drain_fetchstall[%0d]: got %0b want %0b", i, fetchStall_o, exp_fs); else passed++;
    end
  endtask

  task automatic test_short_bundle();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h100, 2'd1, 20'h11, 16'h22, 64'd500, 0, 0);
      else if (i == 1) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h200, 2'd3, 20'h33, 16'h44, 64'd600, 0, 0);
      else step(0, '0, '0, '0, '0, '0, '0, 0, 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL short_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL short_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
    end
  endtask

  task automatic test_decode_stall();
    logic stall_tab [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(i == 0, {$urandom, $urandom, $urandom, $urandom}, 64'h1000, 2'd3, 20'h99, 16'h88, 64'd7, stall_tab[i], 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL dstall_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL dstall_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 23; i++) begin
      if (i < 5) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h2000 + 64'(i*16), 2'd3,
                      20'(i), 16'(i + 8), 64'(1000 + i*4), 1, 0);
      else step(0, '0, '0, '0, '0, '0, '0, 0, 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL bp_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL bp_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
      total++; if (fetchStall_o !== exp_fs) $display("FAIL bp_fetchstall[%0d]: got %0b want %0b", i, fetchStall_o, exp_fs); else passed++;
      total++; if (overflow_o !== exp_ovf) $display("FAIL bp_overflow[%0d]: got %0b want %0b", i, overflow_o, exp_ovf); else passed++;
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h3000 + 64'(i*16), 2'($urandom_range(0, 3)),
                      20'h123, 16'h456, 64'(2000 + i*4), 1, 0);
      else if (i == 3) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h4000, 2'd3, 20'h1, 16'h2, 64'd9, 0, 1);
      else step(0, '0, '0, '0, '0, '0, '0, 0, 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL flush_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if (fetchStall_o !== exp_fs) $display("FAIL flush_fetchstall[%0d]: got %0b want %0b", i, fetchStall_o, exp_fs); else passed++;
      total++; if (overflow_o !== exp_ovf) $display("FAIL flush_overflow[%0d]: got %0b want %0b", i, overflow_o, exp_ovf); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL flush_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
      if (i == 3) begin
        total++; if (dut.count_q !== 3'd0) $display("FAIL flush_count: got %0d want 0", dut.count_q); else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, {$urandom, $urandom, $urandom, $urandom}, 64'h5000, 2'd3, 20'h77, 16'h66, 64'd42, 0, 0);
    step(0, '0, '0, '0, '0, '0, '0, 0, 0);
    total++; if (outputEnable_o !== exp_oe) $display("FAIL areset_pre_oe: got %0b want %0b", outputEnable_o, exp_oe); else passed++;
    #3 reset_i = 1;
    model_reset();
    #1;
    total++; if (outputEnable_o !== 1'b0) $display("FAIL areset_oe: got %0b want 0", outputEnable_o); else passed++;
    total++; if (dut.count_q !== 3'd0) $display("FAIL areset_count: got %0d want 0", dut.count_q); else passed++;
    total++; if (overflow_o !== 1'b0) $display("FAIL areset_overflow: got %0b want 0", overflow_o); else passed++;
    total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== item_t'(0))
      $display("FAIL areset_fields: got %h want 0", {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}); else passed++;
    #2 reset_i = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1, {$urandom, $urandom, $urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFF8, 2'd2, 20'h3, 16'h4,
                       64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
      else step(0, '0, '0, '0, '0, '0, '0, 0, 0);
      total++; if (outputEnable_o !== exp_oe) $display("FAIL recover_oe[%0d]: got %0b want %0b", i, outputEnable_o, exp_oe); else passed++;
      total++; if ({instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o} !== exp_item)
        $display("FAIL recover_fields[%0d]: got %h want %h", i, {instruction_o, instAddress_o, instPid_o, instTid_o, instMajId_o}, exp_item); else passed++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    test_reset();
    test_basic_drain();
    test_short_bundle();
    test_decode_stall();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
